regfile_wb_arbiter: RTL

Shares the single register-file write port between two writeback sources: the ALU result path and the load/memory path.
- Arbitrates with memory priority plus an ALU anti-starvation counter.
- Registers the winning write into one output stage that drives the register file's write_enable/write_reg/write_data.
- Exports a pending-write busy mask and a forwarding tap for hazard and bypass logic.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/wb_prio_arbiter.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file writeback types and default widths.
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_prio_arbiter.sv
// Two-input writeback arbiter: memory has priority, but ALU wins once it has
// been denied STARVE_LIMIT consecutive times.
module wb_prio_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_alu_valid,
  input  logic i_mem_valid,
  output logic o_alu_ready,
  output logic o_mem_ready
);
  localparam int             SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;
  logic          w_force;

  assign w_force = (r_starve == LIM);

  // Readies are gated by reset so nothing handshakes while the stage is held.
  assign o_alu_ready = reset & i_alu_valid & (~i_mem_valid | w_force);
  assign o_mem_ready = reset & i_mem_valid & ~(i_alu_valid & w_force);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_starve <= '0;
    else if (o_alu_ready)
      r_starve <= '0;
    else if (i_alu_valid && !w_force)
      r_starve <= r_starve + 1'b1;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a
// single registered output stage, busy mask, forwarding tap and stall stats.
module regfile_wb_arbiter
  import riscv_pkg::wb_src_e;
  import riscv_pkg::WB_ALU;
  import riscv_pkg::WB_MEM;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int ADDR_W       = riscv_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 write_enable,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [XLEN-1:0]      write_data,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 fwd_valid,
  output logic [ADDR_W-1:0]    fwd_reg,
  output logic [XLEN-1:0]      fwd_data,
  output logic                 grant_src,
  output logic [CNT_W-1:0]     stall_count
);
  logic              w_acc, w_stall;
  logic [ADDR_W-1:0] w_rd;
  logic [XLEN-1:0]   w_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_reg;
  logic [XLEN-1:0]   r_data;
  wb_src_e           r_src;
  logic [CNT_W-1:0]  r_stall;

  wb_prio_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_alu_valid (alu_valid),
    .i_mem_valid (mem_valid),
    .o_alu_ready (alu_ready),
    .o_mem_ready (mem_ready)
  );

  assign w_acc   = alu_ready | mem_ready;
  assign w_rd    = mem_ready ? mem_rd   : alu_rd;
  assign w_data  = mem_ready ? mem_data : alu_data;
  assign w_stall = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);

  // x0 writes complete the handshake but never raise write_enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
      r_src  <= WB_ALU;
    end else if (w_acc) begin
      r_we   <= (w_rd != '0);
      r_reg  <= w_rd;
      r_data <= w_data;
      r_src  <= mem_ready ? WB_MEM : WB_ALU;
    end else begin
      r_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall <= '0;
    else if (w_stall && (r_stall != '1))
      r_stall <= r_stall + 1'b1;
  end

  always_comb begin
    busy_mask = '0;
    if (r_we) busy_mask[r_reg] = 1'b1;
  end

  assign write_enable = r_we;
  assign write_reg    = r_reg;
  assign write_data   = r_data;
  assign fwd_valid    = r_we;
  assign fwd_reg      = r_reg;
  assign fwd_data     = r_data;
  assign grant_src    = r_src;
  assign stall_count  = r_stall;
endmodule
